pulse_gen_multi: RTL and testbench

Parametrised, runtime-programmable successor to the fixed-timing pulse generator. Produces a single pulse, a burst of N pulses, or a continuous train on the rising edge of `init`. Delay, high width and period come from input ports and are latched at trigger time. Sits between the sequencing logic and the stimulus/strobe lines, and reports busy/done status back to the sequencer.

---
 rtl/pulse_gen_multi.sv | 188 ++++++++++++++++++
 tb/tb_pulse_gen_multi.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Runtime-programmable pulse generator: single pulse, N-pulse burst or continuous train.
// Optional macro PULSE_GEN_CNT_EN adds the pulse_cnt rising-edge counter output.
module pulse_gen_multi #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   delay,
  input  logic [CNT_W-1:0]   width,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_n,
  output logic               pulse,
  output logic               busy,
  output logic               done
`ifdef PULSE_GEN_CNT_EN
  ,
  output logic [BURST_W+CNT_W-1:0] pulse_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t             state_q, state_d;
  logic               init_q, init_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic [BURST_W-1:0] n_q, n_d;
  logic               cont_q, cont_d;
  logic               fin_q, fin_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               trig;
  logic [CNT_W-1:0]   w_eff;
  logic [CNT_W-1:0]   low_eff;
  logic [BURST_W-1:0] n_eff;

  // Stop beats a coincident trigger, so it is folded into trig directly.
  assign trig  = init & ~init_q & ~stop;
  assign w_eff = (width == '0) ? CNT_W'(1) : width;
  // Low time is latched instead of P so that P = W+1 cannot overflow CNT_W.
  assign low_eff = (period > w_eff) ? (period - w_eff) : CNT_W'(1);
  assign n_eff   = (mode == 2'b01) ? ((burst_n == '0) ? BURST_W'(1) : burst_n)
                                   : BURST_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      d_q     <= '0;
      w_q     <= '0;
      low_q   <= '0;
      n_q     <= '0;
      cont_q  <= 1'b0;
      fin_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      d_q     <= d_d;
      w_q     <= w_d;
      low_q   <= low_d;
      n_q     <= n_d;
      cont_q  <= cont_d;
      fin_q   <= fin_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; phase counter counts up from 0 and is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    d_d     = d_q;
    w_d     = w_q;
    low_d   = low_q;
    n_d     = n_q;
    cont_d  = cont_q;
    fin_d   = 1'b0;
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else if (trig) begin
      d_d     = delay;
      w_d     = w_eff;
      low_d   = low_eff;
      n_d     = n_eff;
      cont_d  = (mode == 2'b10);
      cnt_d   = '0;
      pcnt_d  = '0;
      state_d = (delay == '0) ? HIGH : DELAY;
    end else begin
      case (state_q)
        DELAY: begin
          if (cnt_q == d_q - CNT_W'(1)) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt_q == w_q - CNT_W'(1)) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == low_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (cont_q) begin
              state_d = HIGH;
            end else if (pcnt_q != n_q - BURST_W'(1)) begin
              state_d = HIGH;
              pcnt_d  = pcnt_q + BURST_W'(1);
            end else begin
              state_d = IDLE;
              pcnt_d  = '0;
              fin_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs trail the state by one edge; stop and retrigger force pulse low immediately.
  always_comb begin
    init_d  = init;
    pulse_d = (state_q == HIGH) & ~stop & ~trig;
    busy_d  = (state_q != IDLE) & ~stop;
    done_d  = fin_q;
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef PULSE_GEN_CNT_EN
  logic [BURST_W+CNT_W-1:0] pcount_q, pcount_d;

  always_comb begin
    pcount_d = pcount_q;
    if (trig) begin
      pcount_d = '0;
    end else if (pulse_d && !pulse_q && !(&pcount_q)) begin
      pcount_d = pcount_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount_q <= '0;
    end else begin
      pcount_q <= pcount_d;
    end
  end

  assign pulse_cnt = pcount_q;
`endif

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed self-checking bench for pulse_gen_multi; waveforms follow the
// spec timing formulas with hand-entered effective D/W/P/N per sequence.
module tb_pulse_gen_multi;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 4;

  logic               clk;
  logic               rst_n;
  logic               init;
  logic               stop;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   delay;
  logic [CNT_W-1:0]   width;
  logic [CNT_W-1:0]   period;
  logic [BURST_W-1:0] burst_n;
  logic               pulse;
  logic               busy;
  logic               done;
`ifdef PULSE_GEN_CNT_EN
  logic [BURST_W+CNT_W-1:0] pulse_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pulse_gen_multi #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .stop    (stop),
    .mode    (mode),
    .delay   (delay),
    .width   (width),
    .period  (period),
    .burst_n (burst_n),
    .pulse   (pulse),
    .busy    (busy),
    .done    (done)
`ifdef PULSE_GEN_CNT_EN
    ,
    .pulse_cnt (pulse_cnt)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    init = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise init; returns 1 time unit after edge T0.
  task automatic start(input logic [1:0] m, input int d, input int w, input int p, input int n);
    mode    = m;
    delay   = CNT_W'(d);
    width   = CNT_W'(w);
    period  = CNT_W'(p);
    burst_n = BURST_W'(n);
    init    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Checks pulse/busy/done at offsets 0..len after the trigger edge.
  task automatic watch(input string tag, input int d, input int w, input int p, input int n,
                       input bit cont, input int len, input int stop_k, input bit busy0);
    int  end_k;
    bit  ph, bz, dn, stopped;
    end_k = cont ? 1000000 : d + 1 + n * p;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        if (k == stop_k) stop = 1'b1;
        @(posedge clk);
        #1;
      end
      stopped = (stop_k >= 0) && (k >= stop_k);
      ph = 1'b0;
      bz = 1'b0;
      dn = 1'b0;
      if (!stopped) begin
        for (int i = 0; i < (cont ? len : n); i++)
          if (k >= d + 1 + i * p && k < d + 1 + i * p + w) ph = 1'b1;
        bz = (k >= 1 || busy0) && k < end_k;
        dn = !cont && (k == end_k);
      end
      check($sformatf("%s.pulse@%0d", tag, k), 32'(pulse), 32'(ph));
      check($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'(bz));
      check($sformatf("%s.done@%0d", tag, k), 32'(done), 32'(dn));
    end
    stop = 1'b0;
    $display("seq %s observed through offset %0d, checks so far %0d", tag, len, checks);
  endtask

  initial begin
    rst_n   = 1'b0;
    init    = 1'b0;
    stop    = 1'b0;
    mode    = 2'b00;
    delay   = '0;
    width   = '0;
    period  = '0;
    burst_n = '0;
    #120;
    check("reset.pulse", 32'(pulse), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single: burst_n ignored, N=1; init held high afterwards must not retrigger.
    start(2'b00, 10, 5, 30, 5);
    watch("single", 10, 5, 30, 1, 1'b0, 45, -1, 1'b0);
`ifdef PULSE_GEN_CNT_EN
    check("single.cnt", 32'(pulse_cnt), 32'd1);
`endif
    idle(2);

    start(2'b01, 0, 2, 4, 3);
    watch("burst", 0, 2, 4, 3, 1'b0, 16, -1, 1'b0);
`ifdef PULSE_GEN_CNT_EN
    check("burst.cnt", 32'(pulse_cnt), 32'd3);
`endif
    idle(2);

    start(2'b10, 2, 1, 3, 0);
    watch("cont", 2, 1, 3, 1, 1'b1, 24, 20, 1'b0);
`ifdef PULSE_GEN_CNT_EN
    check("cont.cnt", 32'(pulse_cnt), 32'd6);
`endif
    idle(2);

    // Clamping: W=0 -> 1, P=0 -> 2.
    start(2'b00, 0, 0, 0, 0);
    watch("clamp", 0, 1, 2, 1, 1'b0, 6, -1, 1'b0);
    idle(2);

    // Reserved mode acts as single; period below width -> P=W+1=5.
    start(2'b11, 1, 4, 3, 3);
    watch("rsvd", 1, 4, 5, 1, 1'b0, 10, -1, 1'b0);
    idle(2);

    // Stop and trigger in the same cycle: nothing starts.
    stop = 1'b1;
    start(2'b00, 0, 3, 6, 1);
    check("stoptrig.busy0", 32'(busy), 32'd0);
    stop = 1'b0;
    @(posedge clk);
    #1;
    check("stoptrig.busy1", 32'(busy), 32'd0);
    check("stoptrig.pulse1", 32'(pulse), 32'd0);
    idle(2);

    // Retrigger mid-burst while pulse is high.
    start(2'b01, 0, 2, 4, 3);
    watch("rt0", 0, 2, 4, 3, 1'b0, 4, -1, 1'b0);
    init = 1'b0;
    @(posedge clk);
    #1;
    check("rt0.pulse@5", 32'(pulse), 32'd1);
    start(2'b01, 4, 2, 4, 3);
    watch("rt1", 4, 2, 4, 3, 1'b0, 20, -1, 1'b1);
`ifdef PULSE_GEN_CNT_EN
    check("rt1.cnt", 32'(pulse_cnt), 32'd3);
`endif
    idle(2);

    // Async reset during HIGH, then init still high triggers on the first edge.
    start(2'b00, 0, 5, 30, 1);
    watch("rst0", 0, 5, 30, 1, 1'b0, 2, -1, 1'b0);
    #20;
    rst_n = 1'b0;
    #1;
    check("rstasync.pulse", 32'(pulse), 32'd0);
    check("rstasync.busy", 32'(busy), 32'd0);
    check("rstasync.done", 32'(done), 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    watch("rst1", 0, 5, 30, 1, 1'b0, 35, -1, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
